// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory responder with fixed-latency, single-outstanding fetch
module imem_responder #(
    parameter int BUS_WIDTH = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [BUS_WIDTH-1:0] req_addr,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [BUS_WIDTH-1:0] resp_data,
    output logic                 resp_err,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [BUS_WIDTH-1:0] wr_data,
    output logic                 busy
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic [BUS_WIDTH-1:0]   resp_data_q;
    logic                   resp_err_q;
    logic [BUS_WIDTH-1:0]   mem_q [DEPTH];
    logic                   addr_oob;

    // Any set bit above the storage index means the fetch is out of range.
    generate
        if (BUS_WIDTH > ADDR_BITS) begin : g_oob
            assign addr_oob = |req_addr[BUS_WIDTH-1:ADDR_BITS];
        end else begin : g_no_oob
            assign addr_oob = 1'b0;
        end
    endgenerate

    // Storage is never cleared; non-blocking update gives read-before-write on a same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        resp_data_q <= addr_oob ? '0 : mem_q[req_addr[ADDR_BITS-1:0]];
                        resp_err_q  <= addr_oob;
                        cnt_q       <= CNT_INIT;
                        state_q     <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, meaning address/data width.
REQ-002 SHALL have parameter ADDR_BITS, default 8, meaning log2 of storage depth in words.
REQ-003 SHALL have parameter LATENCY, default 2, range 1..15, meaning cycles from request accept to response valid.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  fetch request present.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port req_addr  input  BUS_WIDTH  word address of the request.
REQ-009 SHALL have port resp_valid  output  1  response present.
REQ-010 SHALL have port resp_ready  input  1  consumer takes the response.
REQ-011 SHALL have port resp_data  output  BUS_WIDTH  fetched instruction word.
REQ-012 SHALL have port resp_err  output  1  request address was out of range.
REQ-013 SHALL have port wr_en  input  1  storage write strobe.
REQ-014 SHALL have port wr_addr  input  ADDR_BITS  storage write word address.
REQ-015 SHALL have port wr_data  input  BUS_WIDTH  storage write data.
REQ-016 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 SHALL hold 2^ADDR_BITS words of BUS_WIDTH bits; contents not cleared by reset.
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP; one transaction outstanding at most.
REQ-019 SHALL drive req_ready=1 only in IDLE; accept = req_valid & req_ready at a rising edge.
REQ-020 SHALL on accept latch resp_data = mem[req_addr[ADDR_BITS-1:0]] and resp_err=0 when req_addr < 2^ADDR_BITS; else latch resp_data=0 and resp_err=1.
REQ-021 SHALL on accept load a down-counter with LATENCY-1 and enter WAIT; when LATENCY=1 enter RESP directly.
REQ-022 SHALL in WAIT decrement the counter each cycle and enter RESP on the edge where it reads 1.
REQ-023 SHALL assert resp_valid exactly LATENCY cycles after the accept edge, and only in RESP.
REQ-024 SHALL hold resp_valid, resp_data, resp_err stable in RESP until resp_ready=1.
REQ-025 SHALL on resp_valid & resp_ready return to IDLE; req_ready rises the following cycle (peak rate one request per LATENCY+1 cycles).
REQ-026 SHALL drop resp_valid to 0 on leaving RESP; resp_data/resp_err retain last values.
REQ-027 SHALL perform wr_en writes in any state; a write and an accept to the same address in the same cycle SHALL return the old word (read-before-write).
REQ-028 SHALL not affect an already latched response by any later write.
REQ-029 SHALL ignore req_valid outside IDLE and resp_ready outside RESP.

Reset
REQ-030 SHALL, while rst=0 at a rising edge, set state IDLE, counter 0, resp_valid 0, resp_data 0, resp_err 0, busy 0; req_ready 1 after reset releases.
REQ-031 SHALL abandon any in-flight transaction on reset without emitting a response.
REQ-032 SHALL ignore wr_en while rst=0.

Verification
REQ-033 Write mem[0x05]=0xBEEF, request addr 0x0005 accepted at edge k, resp_ready=1 -> resp_valid=1 at cycle k+2, resp_data=0xBEEF, resp_err=0, req_ready=1 at k+3.
REQ-034 Request addr 0x0100 (out of range) -> resp_valid at k+2 with resp_data=0x0000, resp_err=1.
REQ-035 Backpressure: resp_ready=0 for 5 cycles then 1 -> resp_valid/resp_data held unchanged all 5 cycles, req_ready=0 throughout, IDLE after handshake.
REQ-036 Same-cycle wr_en to 0x05 with 0x1234 and accept of addr 0x05 (old 0xBEEF) -> response 0xBEEF; next request to 0x05 -> 0x1234.
REQ-037 rst=0 asserted in WAIT -> next cycle busy=0, resp_valid=0, resp_data=0; no response ever appears for the abandoned request.
REQ-038 LATENCY=1 build: accept at edge k -> resp_valid=1 at cycle k+1; back-to-back requests accepted every 2 cycles with resp_ready=1.
